// File: rtl/evm_pkg.sv
// Shared types and constants for the ballot controller slice.
// State codes double as the front-panel led_state encoding.
package evm_pkg;

  localparam int LED_W = 4;

  localparam logic [LED_W-1:0] LED_IDLE    = 4'd1;
  localparam logic [LED_W-1:0] LED_READY   = 4'd2;
  localparam logic [LED_W-1:0] LED_SELECT  = 4'd3;
  localparam logic [LED_W-1:0] LED_CONFIRM = 4'd4;
  localparam logic [LED_W-1:0] LED_COMMIT  = 4'd5;
  localparam logic [LED_W-1:0] LED_THANKS  = 4'd6;
  localparam logic [LED_W-1:0] LED_CLOSED  = 4'd7;

  typedef enum logic [LED_W-1:0] {
    ST_IDLE    = LED_IDLE,
    ST_READY   = LED_READY,
    ST_SELECT  = LED_SELECT,
    ST_CONFIRM = LED_CONFIRM,
    ST_COMMIT  = LED_COMMIT,
    ST_THANKS  = LED_THANKS,
    ST_CLOSED  = LED_CLOSED
  } evm_state_t;

  function automatic logic [LED_W-1:0] state_to_led(input evm_state_t s);
    return LED_W'(s);
  endfunction

endpackage

// File: rtl/evm_ballot_ctrl_tally.sv
// evm_tally_bank: per-candidate saturating tallies, saturating total,
// sticky saturation flag and a one-cycle-latency readout port.
module evm_tally_bank
  import evm_pkg::*;
#(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8,
  parameter int IDX_W    = $clog2(NUM_CAND)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic [IDX_W-1:0] inc_idx,
  input  logic             clear,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W+3:0] total,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W+3:0] TOT_MAX = '1;

  logic [CNT_W-1:0] tally [NUM_CAND];
  logic [CNT_W-1:0] rd_mux;
  logic             hits_max;

  // Out-of-range read indices fall through the mux and read as zero.
  always_comb begin
    rd_mux   = '0;
    hits_max = 1'b0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (int'(rd_idx) == i) rd_mux = tally[i];
      if (int'(inc_idx) == i && tally[i] >= CNT_MAX - 1'b1) hits_max = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
    end else if (inc) begin
      for (int i = 0; i < NUM_CAND; i++) begin
        if (int'(inc_idx) == i && tally[i] != CNT_MAX) tally[i] <= tally[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      total <= '0;
      sat   <= 1'b0;
    end else if (clear) begin
      total <= '0;
      sat   <= 1'b0;
    end else if (inc) begin
      if (total != TOT_MAX) total <= total + 1'b1;
      if (hits_max) sat <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_count <= '0;
    else          rd_count <= rd_mux;
  end

endmodule

// File: rtl/evm_ballot_ctrl.sv
// Voting-machine controller FSM: admin open/close, select/confirm/commit flow.
// Optional voter idle timeout in SELECT/CONFIRM when EVM_TIMEOUT_EN is defined.
module evm_ballot_ctrl
  import evm_pkg::*;
#(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 8,
  parameter int IDX_W       = $clog2(NUM_CAND),
  parameter int THANKS_CYC  = 6,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             close,
  input  logic             clear,
  input  logic             vote_valid,
  input  logic [IDX_W-1:0] vote_idx,
  input  logic             confirm,
  input  logic             cancel,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             ready,
  output logic             locked,
  output logic [LED_W-1:0] led_state,
  output logic [IDX_W-1:0] sel_cand,
  output logic             bad_sel,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W+3:0] total,
  output logic             sat
);

  localparam int               TMR_W    = (THANKS_CYC > 1) ? $clog2(THANKS_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(THANKS_CYC - 1);

  evm_state_t       state, state_nxt;
  logic             confirm_q;
  logic             conf_rise;
  logic             close_pend;
  logic [TMR_W-1:0] timer;
  logic             vote_ok;
  logic             timeout_hit;
  logic             sel_take;
  logic             sel_bad;

  assign conf_rise = confirm & ~confirm_q;
  assign vote_ok   = int'(vote_idx) < NUM_CAND;
  assign sel_take  = (state == ST_READY) && !close && vote_valid && vote_ok;
  assign sel_bad   = (state == ST_READY) && !close && vote_valid && !vote_ok;

`ifdef EVM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] idle_cnt;
  logic            waiting;
  logic            activity;

  assign waiting     = (state == ST_SELECT) || (state == ST_CONFIRM);
  assign activity    = vote_valid | confirm | cancel;
  assign timeout_hit = waiting && !activity && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Count only uninterrupted idle cycles while a voter holds the booth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 idle_cnt <= '0;
    else if (waiting && !activity) idle_cnt <= idle_cnt + 1'b1;
    else                          idle_cnt <= '0;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Cancel outranks confirm everywhere; a held confirm never produces a rise.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_READY;
      ST_READY: begin
        if (close)         state_nxt = ST_CLOSED;
        else if (sel_take) state_nxt = ST_SELECT;
      end
      ST_SELECT: begin
        if (cancel)           state_nxt = ST_READY;
        else if (conf_rise)   state_nxt = ST_CONFIRM;
        else if (timeout_hit) state_nxt = ST_READY;
      end
      ST_CONFIRM: begin
        if (cancel)           state_nxt = ST_READY;
        else if (conf_rise)   state_nxt = ST_COMMIT;
        else if (timeout_hit) state_nxt = ST_READY;
      end
      ST_COMMIT:  state_nxt = ST_THANKS;
      ST_THANKS: begin
        // A close landing on the final THANKS cycle is honoured too.
        if (timer == '0) state_nxt = (close_pend || close) ? ST_CLOSED : ST_READY;
      end
      ST_CLOSED:  if (start) state_nxt = ST_READY;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      confirm_q  <= 1'b0;
      sel_cand   <= '0;
      bad_sel    <= 1'b0;
      timer      <= '0;
      close_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      confirm_q <= confirm;
      bad_sel   <= sel_bad;
      if (sel_take) sel_cand <= vote_idx;

      if (state == ST_COMMIT)                      timer <= TMR_LOAD;
      else if (state == ST_THANKS && timer != '0)  timer <= timer - 1'b1;

      if (state == ST_THANKS && timer == '0)                    close_pend <= 1'b0;
      else if ((state == ST_COMMIT || state == ST_THANKS) && close) close_pend <= 1'b1;
    end
  end

  assign ready     = (state == ST_READY) || (state == ST_SELECT);
  assign locked    = (state == ST_COMMIT) || (state == ST_THANKS);
  assign led_state = state_to_led(state);

  evm_tally_bank #(
    .NUM_CAND (NUM_CAND),
    .CNT_W    (CNT_W),
    .IDX_W    (IDX_W)
  ) u_tally (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (state == ST_COMMIT),
    .inc_idx  (sel_cand),
    .clear    (clear && (state == ST_IDLE || state == ST_CLOSED)),
    .rd_idx   (rd_idx),
    .rd_count (rd_count),
    .total    (total),
    .sat      (sat)
  );

endmodule
